// File: rtl/fnd_disp_scheduler_pkg.sv
// Shared types and constants for the FND display scheduler.
//   ADDR_*    : FND_Periph register addresses
//   state_e   : bus sequencer states
//   wr_e      : register write slots, in issue order
//   disp_req_t: latched display request payload
package fnd_sched_pkg;

  localparam logic [3:0] ADDR_FCR  = 4'h0;
  localparam logic [3:0] ADDR_FDR  = 4'h4;
  localparam logic [3:0] ADDR_DPR  = 4'h8;
  localparam logic [3:0] ADDR_MODE = 4'hC;

  localparam int unsigned MAX_DISP_DEF = 9999;
  localparam int unsigned NWR          = 4;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;
  typedef enum logic [1:0] {W_FDR, W_DPR, W_MODE, W_FCR} wr_e;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [1:0]  mode;
    logic        en;
  } disp_req_t;

  // Register address for a write slot.
  function automatic logic [3:0] wr_addr(input wr_e w);
    case (w)
      W_FDR:   wr_addr = ADDR_FDR;
      W_DPR:   wr_addr = ADDR_DPR;
      W_MODE:  wr_addr = ADDR_MODE;
      default: wr_addr = ADDR_FCR;
    endcase
  endfunction

  // Zero-extended write data for a write slot.
  function automatic logic [31:0] wr_data(input wr_e w, input disp_req_t r);
    case (w)
      W_FDR:   wr_data = 32'(r.value);
      W_DPR:   wr_data = 32'(r.dp);
      W_MODE:  wr_data = 32'(r.mode);
      default: wr_data = 32'(r.en);
    endcase
  endfunction

  // Lowest pending slot; only meaningful when the mask is non-zero.
  function automatic wr_e first_pend(input logic [NWR-1:0] m);
    if (m[0])      first_pend = W_FDR;
    else if (m[1]) first_pend = W_DPR;
    else if (m[2]) first_pend = W_MODE;
    else           first_pend = W_FCR;
  endfunction

endpackage

// File: rtl/fnd_disp_scheduler_if.sv
// APB write-only bus between the scheduler (master) and FND_Periph (slave).
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE: master -> slave
//   PREADY                          : slave -> master
interface fnd_disp_scheduler_if;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic        PREADY;

  modport master (output PADDR, PWDATA, PWRITE, PSEL, PENABLE, input PREADY);
  modport slave  (input PADDR, PWDATA, PWRITE, PSEL, PENABLE, output PREADY);
endinterface

// File: rtl/fnd_disp_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : last granted index; search starts at ptr+1 and wraps
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : index of the granted requester
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx
);
  localparam int unsigned IW = $clog2(NREQ);

  // First requester above ptr, wrapping around.
  always_comb begin
    int unsigned k;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      k = (32'(ptr) + i) % NREQ;
      if (!found && req[IW'(k)]) begin
        found          = 1'b1;
        gnt[IW'(k)]    = 1'b1;
        gnt_idx        = IW'(k);
      end
    end
  end
endmodule

// File: rtl/fnd_disp_scheduler.sv
// APB master sharing the FND peripheral between NREQ display requesters.
//   PCLK, PRESET         : clock, async active-low reset
//   req_valid/req_ready  : per-requester handshake (ready is a grant pulse)
//   req_value/dp/mode/en : packed per-requester payloads
//   apb                  : APB master port to FND_Periph
//   busy, owner          : sequencer activity and granted requester
//   done, timeout_err    : completion / abort pulses
module fnd_disp_scheduler
  import fnd_sched_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned MAX_DISP = MAX_DISP_DEF
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [16*NREQ-1:0]      req_value,
  input  logic [4*NREQ-1:0]       req_dp,
  input  logic [2*NREQ-1:0]       req_mode,
  input  logic [NREQ-1:0]         req_en,
  fnd_disp_scheduler_if.master    apb,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    done,
  output logic                    timeout_err
);
  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, gidx;
  logic [NREQ-1:0] gnt;
  disp_req_t       new_req, req_q, req_d, sh_q;
  logic [NWR-1:0]  new_pend, pend_q, pend_d, shv_q;
  wr_e             cur_q, cur_d;
  logic [CW-1:0]   cnt_q;
  logic            take, wr_ok, abort;
  logic            psel_q, penable_q;
  logic [3:0]      paddr_q;
  logic [31:0]     pwdata_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gidx)
  );

  // Grant handshake is answered in the same IDLE cycle the request is seen.
  assign req_ready = (state_q == IDLE && PRESET) ? gnt : '0;

  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = psel_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;

  // Winner's payload with the display value saturated.
  always_comb begin
    new_req = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gidx == IW'(i)) begin
        new_req.value = req_value[16*i +: 16];
        new_req.dp    = req_dp[4*i +: 4];
        new_req.mode  = req_mode[2*i +: 2];
        new_req.en    = req_en[i];
      end
    end
    if (new_req.value > 16'(MAX_DISP)) new_req.value = 16'(MAX_DISP);
  end

  // A write is skipped only when its shadow is valid and already matches.
  always_comb begin
    new_pend          = '0;
    new_pend[W_FDR]   = !(shv_q[W_FDR]  && sh_q.value == new_req.value);
    new_pend[W_DPR]   = !(shv_q[W_DPR]  && sh_q.dp    == new_req.dp);
    new_pend[W_MODE]  = !(shv_q[W_MODE] && sh_q.mode  == new_req.mode);
    new_pend[W_FCR]   = !(shv_q[W_FCR]  && sh_q.en    == new_req.en);
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and sequencing control.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    wr_ok   = 1'b0;
    abort   = 1'b0;
    pend_d  = pend_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          take    = 1'b1;
          req_d   = new_req;
          pend_d  = new_pend;
          state_d = (|new_pend) ? SETUP : DONE;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (apb.PREADY) begin
          wr_ok   = 1'b1;
          pend_d  = pend_q & ~NWR'(4'b0001 << cur_q);
          state_d = (|pend_d) ? SETUP : DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          abort   = 1'b1;
          pend_d  = '0;
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cur_d = first_pend(pend_d);

  // Registered outputs, latched request, shadows and wait counter.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      owner       <= '0;
      ptr_q       <= IW'(NREQ - 1);
      req_q       <= '0;
      pend_q      <= '0;
      cur_q       <= W_FDR;
      cnt_q       <= '0;
      sh_q        <= '0;
      shv_q       <= '0;
    end else begin
      psel_q      <= (state_d == SETUP) || (state_d == ACCESS);
      penable_q   <= (state_d == ACCESS);
      busy        <= (state_d != IDLE);
      done        <= (state_q == DONE);
      timeout_err <= abort;
      req_q       <= req_d;
      pend_q      <= pend_d;
      cur_q       <= cur_d;
      cnt_q       <= (state_q == ACCESS && !apb.PREADY) ? cnt_q + CW'(1) : '0;
      if (take) begin
        ptr_q <= gidx;
        owner <= gidx;
      end
      if (state_d == SETUP) begin
        paddr_q  <= wr_addr(cur_d);
        pwdata_q <= wr_data(cur_d, req_d);
      end
      if (wr_ok) begin
        shv_q[cur_q] <= 1'b1;
        case (cur_q)
          W_FDR:   sh_q.value <= req_q.value;
          W_DPR:   sh_q.dp    <= req_q.dp;
          W_MODE:  sh_q.mode  <= req_q.mode;
          default: sh_q.en    <= req_q.en;
        endcase
      end
      if (abort) shv_q <= '0;
    end
  end
endmodule
